// File: rtl/mem_ctrl.sv
// mem_ctrl: LC-3 load/store initiator for the SPRAM memory block; define MEM_CTRL_MMIO_EN to decode the xFE00-xFFFF device window
module mem_ctrl #(
    parameter logic [15:0] MMIO_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ack,
    input  logic        dsp_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, RESP} state_t;
    state_t state, state_nx;
    logic acc, win;
    assign req_ready = (state == IDLE) && rst_n;
    assign acc       = req_valid && req_ready;
    assign mem_we    = state == WRITE;
    assign rsp_valid = state == RESP;
`ifdef MEM_CTRL_MMIO_EN
    logic [15:0] dev_rdata;
    logic        kbd_rd, ddr_wr;
    assign win       = req_addr >= MMIO_BASE;
    assign dev_rdata = req_addr == MMIO_BASE          ? {kbd_valid, 15'b0} :
                       req_addr == MMIO_BASE + 16'd2 ? {8'b0, kbd_data}   :
                       req_addr == MMIO_BASE + 16'd4 ? {dsp_ready, 15'b0} : 16'h0;
    assign kbd_ack   = kbd_rd;
    assign dsp_valid = ddr_wr;
    // device side effects are flagged at accept so they pulse exactly in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kbd_rd   <= 1'b0;
            ddr_wr   <= 1'b0;
            dsp_data <= 8'h0;
        end else begin
            kbd_rd <= acc && win && !req_we && req_addr == MMIO_BASE + 16'd2;
            ddr_wr <= acc && win && req_we && req_addr == MMIO_BASE + 16'd6;
            if (acc && win && req_we && req_addr == MMIO_BASE + 16'd6)
                dsp_data <= req_wdata[7:0];
        end
    end
`else
    logic unused_dev;
    assign win        = 1'b0;
    assign kbd_ack    = 1'b0;
    assign dsp_valid  = 1'b0;
    assign dsp_data   = 8'h0;
    assign unused_dev = ^{kbd_valid, kbd_data, dsp_ready, MMIO_BASE};
`endif
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = !req_valid ? IDLE : win ? RESP : req_we ? WRITE : RD_ADDR;
            WRITE:   state_nx = RESP;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= 16'h0;
            mem_wdata <= 16'h0;
            rsp_rdata <= 16'h0;
        end else begin
            state <= state_nx;
            if (acc) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (state == RD_DATA)
                rsp_rdata <= mem_rdata;
`ifdef MEM_CTRL_MMIO_EN
            if (acc && win && !req_we)
                rsp_rdata <= dev_rdata;
`endif
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven check of mem_ctrl against an SPRAM model with one-cycle registered read
module tb_mem_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_ready;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        rsp_valid, mem_we, kbd_ack, dsp_valid;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 0;
    logic        kbd_valid = 0, dsp_ready = 0;
    logic [7:0]  kbd_data = 0, dsp_data;
    logic [15:0] mem [0:65535];
    int n_cmp = 0, n_bad = 0;
    int we_cnt = 0, rsp_cnt = 0, ack_cnt = 0, dv_cnt = 0;
    logic [15:0] last_rd = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
    } vec_t;
    vec_t vq[$];

    mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
        .dsp_ready(dsp_ready), .dsp_valid(dsp_valid), .dsp_data(dsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (rsp_valid) rsp_cnt++;
        if (kbd_ack) ack_cnt++;
        if (dsp_valid) dv_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        int n, lat, we0;
        logic [15:0] exp_rd;
        exp_rd = v.we ? last_rd : v.rdata;
        @(negedge clk);
        we0 = we_cnt;
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_wait", n < 20, 1);
        @(negedge clk);
        req_valid = 0; req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wdata;
        if (v.lat == 1) begin
            chk("wr_mem_we", mem_we, 1);
            chk("wr_mem_addr", mem_addr, v.addr);
            chk("wr_mem_wdata", mem_wdata, v.wdata);
        end
        chk("busy_ready", req_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        chk($sformatf("lat_%h", v.addr), lat, v.lat);
        chk($sformatf("rdata_%h", v.addr), rsp_rdata, exp_rd);
        chk("we_pulses", we_cnt - we0, v.lat == 1 ? 1 : 0);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
        req_we = 0;
        last_rd = exp_rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, w0, a0, acc_n, bad_pat;
        vq.push_back('{1, 16'h3000, 16'h1234, 16'h0, 1});
        vq.push_back('{0, 16'h3000, 16'h0, 16'h1234, 2});
        vq.push_back('{1, 16'h0000, 16'hAAAA, 16'h0, 1});
        vq.push_back('{1, 16'h4000, 16'h5555, 16'h0, 1});
        vq.push_back('{1, 16'h8000, 16'h0F0F, 16'h0, 1});
        vq.push_back('{1, 16'hC000, 16'hF00D, 16'h0, 1});
        vq.push_back('{0, 16'h0000, 16'h0, 16'hAAAA, 2});
        vq.push_back('{0, 16'h4000, 16'h0, 16'h5555, 2});
        vq.push_back('{0, 16'h8000, 16'h0, 16'h0F0F, 2});
        vq.push_back('{0, 16'hC000, 16'h0, 16'hF00D, 2});
`ifdef MEM_CTRL_MMIO_EN
        vq.push_back('{0, 16'hFE00, 16'h0, 16'h8000, 0});
        vq.push_back('{0, 16'hFE02, 16'h0, 16'h0041, 0});
        vq.push_back('{1, 16'hFE06, 16'h0A07, 16'h0, 0});
        vq.push_back('{0, 16'hFE04, 16'h0, 16'h0000, 0});
        vq.push_back('{1, 16'hFE02, 16'hFFFF, 16'h0, 0});
        vq.push_back('{0, 16'hFE10, 16'h0, 16'h0000, 0});
`else
        vq.push_back('{1, 16'hFE02, 16'hBEEF, 16'h0, 1});
        vq.push_back('{0, 16'hFE02, 16'h0, 16'hBEEF, 2});
`endif
        kbd_valid = 1; kbd_data = 8'h41; dsp_ready = 0;

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_dsp", {kbd_ack, dsp_valid, dsp_data}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        for (int i = 0; i < vq.size(); i++) begin
            if (i == 10) w0 = we_cnt;
            do_req(vq[i]);
        end
`ifdef MEM_CTRL_MMIO_EN
        chk("kbd_ack_cnt", ack_cnt, 1);
        chk("dsp_valid_cnt", dv_cnt, 1);
        chk("dsp_data", dsp_data, 8'h07);
        chk("mmio_no_we", we_cnt - w0, 0);
`else
        chk("no_kbd_ack", ack_cnt, 0);
        chk("no_dsp_valid", dv_cnt, 0);
`endif

        // back-to-back loads with req_valid held high
        @(negedge clk);
        r0 = rsp_cnt; acc_n = 0; bad_pat = 0;
        req_valid = 1; req_we = 0; req_addr = 16'h4000;
        for (int i = 0; i < 16; i++) begin
            if (req_ready !== (i % 4 == 0)) bad_pat++;
            if (req_ready && req_valid) acc_n++;
            @(negedge clk);
        end
        req_valid = 0;
        repeat (4) @(negedge clk);
        chk("b2b_ready_pattern", bad_pat, 0);
        chk("b2b_accepts", acc_n, 4);
        chk("b2b_rsp_count", rsp_cnt - r0, acc_n);
        chk("b2b_rdata", rsp_rdata, 16'h5555);

        // reset during RD_DATA
        req_valid = 1; req_we = 0; req_addr = 16'h3000;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        r0 = rsp_cnt;
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_outs", {mem_we, mem_addr, mem_wdata, rsp_rdata}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_ready_back", req_ready, 1);
        chk("mid_rst_no_rsp", rsp_cnt - r0, 0);

        // reset coinciding with the WRITE edge: store still lands
        req_valid = 1; req_we = 1; req_addr = 16'h5000; req_wdata = 16'h7777;
        @(negedge clk);
        req_valid = 0;
        chk("wr_rst_we", mem_we, 1);
        r0 = rsp_cnt;
        rst_n = 0;
        @(negedge clk);
        chk("wr_rst_we_cleared", mem_we, 0);
        rst_n = 1;
        @(negedge clk);
        chk("wr_rst_no_rsp", rsp_cnt - r0, 0);
        last_rd = 16'h0;
        do_req('{0, 16'h5000, 16'h0, 16'h7777, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
